// File: rtl/mul16_seq_pkg.sv
// Shared constants and state encoding for the mul16_seq multiplier.
// Consumers pull these in with an import of mul16_seq_pkg.
package mul16_seq_pkg;

    localparam int WIDTH       = 16;
    localparam int CNT_W       = 5;
    localparam int MUL16_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL16_STEPS - 1);

endpackage

// File: rtl/mul16_seq_add16.sv
// Fixed-width 16-bit adder used by the multiplier's accumulate path.
// No carry-out: callers recover the carry with an unsigned compare.
module mul16_seq_add16
    import mul16_seq_pkg::*;
(
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b
);

    assign sum = a + b;

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-add multiplier, low 16 bits kept, exact overflow flag.
// Optional macro MUL16_EARLY_TERM_EN ends RUN once no multiplier bits remain.
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             mc_hi;
    logic             ov;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_nxt;
    logic             add_en;
    logic             carry;
    logic             ov_nxt;
    logic             last_step;

    mul16_seq_add16 u_add (
        .sum (sum),
        .a   (acc),
        .b   (mcand)
    );

    assign add_en  = mplier[0];
    assign carry   = (sum < acc);
    assign acc_nxt = add_en ? sum : acc;
    // A set bit already shifted out of mcand means this addend is >= 2^16.
    assign ov_nxt  = ov | (add_en & (carry | mc_hi));

`ifdef MUL16_EARLY_TERM_EN
    assign last_step = (mplier[WIDTH-1:1] == '0);
`else
    assign last_step = (cnt == LAST_CNT);
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last_step) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE: busy = 1'b0;
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath: capture operands, one shift-add step per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            mc_hi   <= 1'b0;
            ov      <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        mc_hi  <= 1'b0;
                        ov     <= 1'b0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    ov     <= ov_nxt;
                    mc_hi  <= mc_hi | mcand[WIDTH-1];
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        product <= acc_nxt;
                        ovf     <= ov_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq with an expected-result queue.
// Expected products come from a 32-bit reference multiply in the bench.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] p;
        logic        o;
        int          len;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mul16_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input logic [15:0] m);
        int n;
        n = 1;
        for (int i = 0; i < 16; i++) if (m[i]) n = i + 1;
`ifndef MUL16_EARLY_TERM_EN
        n = 16;
`endif
        return n;
    endfunction

    // Drive one start pulse across a posedge; returns just after that edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [31:0] f;
        f     = 32'(x) * 32'(y);
        e.p   = f[15:0];
        e.o   = (f[31:16] != 16'h0);
        e.len = run_len(y);
        sb.push_back(e);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    // Wait (bounded) for done, then compare against the queue head.
    task automatic wait_done(input string tag, input int pre);
        int   cyc;
        bit   seen;
        exp_t e;
        logic [15:0] held;
        cyc  = pre;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else cyc++;
        end
        check({tag, "/done_seen"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "/sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "/product"}, 32'(product), 32'(e.p));
            check({tag, "/ovf"}, 32'(ovf), 32'(e.o));
            check({tag, "/run_len"}, 32'(cyc), 32'(e.len));
            check({tag, "/busy_in_done"}, 32'(busy), 32'd1);
        end
        held = product;
        @(negedge clk);
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/held"}, 32'(product), 32'(held));
    endtask

    initial begin
        int npulse;
        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/product", 32'(product), 32'd0);
        check("rst/ovf", 32'(ovf), 32'd0);

        issue(16'd3, 16'd5);
        wait_done("t1_3x5", 0);
        issue(16'hFFFF, 16'hFFFF);
        wait_done("t2_ffff", 0);
        issue(16'h0100, 16'h0100);
        wait_done("t3_shift_out", 0);
        issue(16'h1234, 16'h0000);
        wait_done("t4_b0", 0);
        issue(16'h0001, 16'h8000);
        wait_done("t4b_msb", 0);

        // Re-pulse start mid-RUN; it must be dropped, not queued.
        issue(16'd3, 16'd5);
        @(negedge clk);
        a     = 16'd7;
        b     = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_ignore", 2);
        npulse = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("t5/extra_done", 32'(npulse), 32'd0);
        check("t5/still_idle", 32'(busy), 32'd0);

        // Abort with reset at RUN step 8.
        issue(16'd3, 16'hFFFF);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("t6/busy", 32'(busy), 32'd0);
        check("t6/done", 32'(done), 32'd0);
        check("t6/product", 32'(product), 32'd0);
        check("t6/ovf", 32'(ovf), 32'd0);
        issue(16'd2, 16'd9);
        wait_done("t6_fresh", 0);

        for (int k = 0; k < 4; k++) begin
            issue(16'($urandom), 16'($urandom));
            wait_done("rand", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
